regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU writeback path
// (req0) and the load/memory writeback path (req1). Each path parks one (rd, data)
// pair in a one-entry buffer. A grant picks one buffered entry per cycle, and that
// entry drives the registered regWrite/rd/writeData outputs.
// The q_pend outputs flag any register that still has a write queued or on the
// output stage, so the hazard unit can stall readers of it.
//
// Optional build macro: WB_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority (req0 wins every tie; req1 can starve)
//   undefined -> round-robin between the two buffers (default)
module regfile_wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int RBITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [RBITS-1:0] req0_rd,
  input  logic [XLEN-1:0]  req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [RBITS-1:0] req1_rd,
  input  logic [XLEN-1:0]  req1_data,
  output logic             regWrite,
  output logic [RBITS-1:0] rd,
  output logic [XLEN-1:0]  writeData,
  input  logic [RBITS-1:0] q_rs1,
  input  logic [RBITS-1:0] q_rs2,
  output logic             q_pend1,
  output logic             q_pend2
);

  logic             bufValid0, bufValid1;
  logic [RBITS-1:0] bufRd0, bufRd1;
  logic [XLEN-1:0]  bufData0, bufData1;
  logic             grant0, grant1;
  logic             take0, take1;
  logic             anyGrant;
  logic [RBITS-1:0] grantedRd;
  logic [XLEN-1:0]  grantedData;

`ifdef WB_ARB_FIXED_PRIO_EN
  // Fixed priority: req0 wins every tie, so no grant history is needed.
  always_comb begin
    grant0 = bufValid0;
    grant1 = bufValid1 && !bufValid0;
  end
`else
  logic lastGrant;

  // Round-robin: a lone valid buffer is granted; on a tie the buffer that
  // was not granted last time wins.
  always_comb begin
    grant0 = bufValid0 && (!bufValid1 || lastGrant);
    grant1 = bufValid1 && (!bufValid0 || !lastGrant);
  end

  // Remember the last granted index. Reset to 1 so that req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant <= 1'b1;
    end else if (grant0) begin
      lastGrant <= 1'b0;
    end else if (grant1) begin
      lastGrant <= 1'b1;
    end
  end
`endif

  // Ready depends on buffer state only. A buffer being drained this cycle can
  // take a new entry on the same edge, so a lone requester streams at full rate.
  always_comb begin
    req0_ready = !bufValid0 || grant0;
    req1_ready = !bufValid1 || grant1;
    take0      = req0_valid && req0_ready;
    take1      = req1_valid && req1_ready;
  end

  // Holding buffer for req0: a new transfer reloads it, a bare grant empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bufValid0 <= 1'b0;
      bufRd0    <= '0;
      bufData0  <= '0;
    end else if (take0) begin
      bufValid0 <= 1'b1;
      bufRd0    <= req0_rd;
      bufData0  <= req0_data;
    end else if (grant0) begin
      bufValid0 <= 1'b0;
    end
  end

  // Holding buffer for req1: same policy as buffer 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bufValid1 <= 1'b0;
      bufRd1    <= '0;
      bufData1  <= '0;
    end else if (take1) begin
      bufValid1 <= 1'b1;
      bufRd1    <= req1_rd;
      bufData1  <= req1_data;
    end else if (grant1) begin
      bufValid1 <= 1'b0;
    end
  end

  // Select the granted entry's values for the output stage.
  always_comb begin
    anyGrant    = grant0 || grant1;
    grantedRd   = grant0 ? bufRd0 : bufRd1;
    grantedData = grant0 ? bufData0 : bufData1;
  end

  // Output stage. A granted x0 entry is consumed without a write, because the
  // register file does not hard-wire x0. rd and writeData hold when there is no grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite  <= 1'b0;
      rd        <= '0;
      writeData <= '0;
    end else begin
      regWrite <= anyGrant && (grantedRd != '0);
      if (anyGrant) begin
        rd        <= grantedRd;
        writeData <= grantedData;
      end
    end
  end

  // Pending-write query for the hazard unit. It covers both buffers and the output stage.
  always_comb begin
    q_pend1 = (q_rs1 != '0) &&
              ((bufValid0 && (bufRd0 == q_rs1)) ||
               (bufValid1 && (bufRd1 == q_rs1)) ||
               (regWrite  && (rd     == q_rs1)));
    q_pend2 = (q_rs2 != '0) &&
              ((bufValid0 && (bufRd0 == q_rs2)) ||
               (bufValid1 && (bufRd1 == q_rs2)) ||
               (regWrite  && (rd     == q_rs2)));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter. Expected writes are queued as stimulus is issued
// and checked in order when regWrite is seen. A register-file model holds the
// final values.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_rd, req1_rd;
  logic [63:0] req0_data, req1_data;
  logic        regWrite;
  logic [4:0]  rd;
  logic [63:0] writeData;
  logic [4:0]  q_rs1, q_rs2;
  logic        q_pend1, q_pend2;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;
  wr_t expq[$];
  logic [63:0] rfModel[32];

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       p1;
    logic       p2;
  } qvec_t;
  qvec_t qtab[5];

  regfile_wb_arbiter #(.XLEN(64), .RBITS(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .regWrite(regWrite), .rd(rd), .writeData(writeData),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_pend1(q_pend1), .q_pend2(q_pend2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  task automatic pushExp(input logic [4:0] r, input logic [63:0] d);
    wr_t e;
    e.rd = r;
    e.data = d;
    expq.push_back(e);
  endtask

  // Scoreboard: every write the DUT issues must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b0 && regWrite === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL unexpected_write actual rd=%0d data=%0h required none", rd, writeData);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("wb_order", {rd, writeData}, {e.rd, e.data});
      end
      rfModel[rd] = writeData;
    end
  end

  // Drive one request and wait, with a time limit, for the handshake. Call this
  // at posedge+1. It returns at posedge+1 after the transfer edge.
  task automatic send(input int port, input logic [4:0] r, input logic [63:0] d,
                      input bit push, output bit ok);
    bit rdy;
    ok = 1'b0;
    if (port == 0) begin req0_valid = 1'b1; req0_rd = r; req0_data = d; end
    else           begin req1_valid = 1'b1; req1_rd = r; req1_data = d; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      rdy = (port == 0) ? req0_ready : req1_ready;
      if (rdy) begin
        if (push && r != 5'd0) pushExp(r, d);
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL handshake_timeout port=%0d actual=no_ready required=ready", port);
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok0, ok1;
    qtab[0] = '{5'd3,  5'd9,  1'b1, 1'b1};
    qtab[1] = '{5'd9,  5'd4,  1'b1, 1'b0};
    qtab[2] = '{5'd0,  5'd3,  1'b0, 1'b1};
    qtab[3] = '{5'd4,  5'd10, 1'b0, 1'b0};
    qtab[4] = '{5'd0,  5'd0,  1'b0, 1'b0};

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_rd = '0; req1_rd = '0; req0_data = '0; req1_data = '0;
    q_rs1 = 5'd5; q_rs2 = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_regWrite", regWrite, 1'b0);
    chk("rst_rd", rd, 5'd0);
    chk("rst_writeData", writeData, 64'd0);
    chk("rst_ready0", req0_ready, 1'b1);
    chk("rst_ready1", req1_ready, 1'b1);
    chk("rst_pend1", q_pend1, 1'b0);
    chk("rst_pend2", q_pend2, 1'b0);

    // Both buffers loaded on the same edge. Query table applied within one cycle.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 64'h33;
    req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 64'h99;
    @(negedge clk);
    chk("pair_ready0", req0_ready, 1'b1);
    chk("pair_ready1", req1_ready, 1'b1);
    pushExp(5'd3, 64'h33);
    pushExp(5'd9, 64'h99);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q_rs1 = qtab[i].rs1;
      q_rs2 = qtab[i].rs2;
      #1;
      chk($sformatf("qtab%0d_pend1", i), q_pend1, qtab[i].p1);
      chk($sformatf("qtab%0d_pend2", i), q_pend2, qtab[i].p2);
    end
    repeat (4) @(negedge clk);

    // Lone req0 write: 2-edge latency, one-cycle pulse, pending coverage
    @(posedge clk); #1;
    q_rs1 = 5'd5;
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 64'hAA;
    @(negedge clk);
    chk("lone_ready", req0_ready, 1'b1);
    chk("lone_pend_pre", q_pend1, 1'b0);
    pushExp(5'd5, 64'hAA);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("lone_e0_regWrite", regWrite, 1'b0);
    chk("lone_e0_pend", q_pend1, 1'b1);
    @(negedge clk);
    chk("lone_e1_regWrite", regWrite, 1'b1);
    chk("lone_e1_rd", rd, 5'd5);
    chk("lone_e1_data", writeData, 64'hAA);
    chk("lone_e1_pend", q_pend1, 1'b1);
    @(negedge clk);
    chk("lone_e2_regWrite", regWrite, 1'b0);
    chk("lone_e2_pend", q_pend1, 1'b0);

    // Both requesters stream four entries each
    @(posedge clk); #1;
    pulseReset();
`ifdef WB_ARB_FIXED_PRIO_EN
    for (int i = 1; i <= 4; i++) pushExp(5'(i), 64'h100 + 64'(i));
    for (int i = 1; i <= 4; i++) pushExp(5'(10 + i), 64'h200 + 64'(i));
`else
    for (int i = 1; i <= 4; i++) begin
      pushExp(5'(i), 64'h100 + 64'(i));
      pushExp(5'(10 + i), 64'h200 + 64'(i));
    end
`endif
    fork
      begin
        bit ok;
        for (int i = 1; i <= 4; i++) send(0, 5'(i), 64'h100 + 64'(i), 1'b0, ok);
      end
      begin
        bit ok;
        for (int i = 1; i <= 4; i++) send(1, 5'(10 + i), 64'h200 + 64'(i), 1'b0, ok);
      end
    join
    repeat (6) @(negedge clk);
    chk("stream_drained", expq.size(), 0);

    // req1 targets x0: handshake completes, no write, no pending
    @(posedge clk); #1;
    q_rs1 = 5'd0;
    send(1, 5'd0, 64'h55, 1'b0, ok1);
    chk("x0_handshake", ok1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("x0_regWrite%0d", i), regWrite, 1'b0);
      chk($sformatf("x0_pend%0d", i), q_pend1, 1'b0);
    end

    // Same rd from both on the first tie: req0 then req1, and req1's value stays
    @(posedge clk); #1;
    pulseReset();
    pushExp(5'd7, 64'h1);
    pushExp(5'd7, 64'h2);
    fork
      send(0, 5'd7, 64'h1, 1'b0, ok0);
      send(1, 5'd7, 64'h2, 1'b0, ok1);
    join
    repeat (4) @(negedge clk);
    chk("same_rd_final", rfModel[7], 64'h2);

    // Reset while both buffers are loaded discards them
    @(posedge clk); #1;
    fork
      send(0, 5'd20, 64'hDEAD, 1'b0, ok0);
      send(1, 5'd21, 64'hBEEF, 1'b0, ok1);
    join
    pulseReset();
    @(negedge clk);
    chk("rstmid_ready0", req0_ready, 1'b1);
    chk("rstmid_ready1", req1_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstmid_regWrite%0d", i), regWrite, 1'b0);
      @(negedge clk);
    end

    chk("sb_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
